// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: decoded operation, FSM state,
// and the main-decoder ALUOp class encodings.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_SLL     = 4'd2,
        OP_SLT     = 4'd3,
        OP_SLTU    = 4'd4,
        OP_XOR     = 4'd5,
        OP_SRL     = 4'd6,
        OP_SRA     = 4'd7,
        OP_OR      = 4'd8,
        OP_AND     = 4'd9,
        OP_MUL     = 4'd10,
        OP_MULHU   = 4'd11,
        OP_DIVU    = 4'd12,
        OP_REMU    = 4'd13,
        OP_ILLEGAL = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of ALUOp/funct fields into a single alu_op_t.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    input  logic       opb5,
    output alu_op_t    op
);

    // Map instruction fields to an operation; anything unmapped is ILLEGAL.
    always_comb begin
        op = OP_ILLEGAL;
        case (ALUOp)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_FUNCT: begin
                if (opb5 && funct7b0) begin
                    case (funct3)
                        3'b000:  op = OP_MUL;
                        3'b011:  op = OP_MULHU;
                        3'b101:  op = OP_DIVU;
                        3'b111:  op = OP_REMU;
                        default: op = OP_ILLEGAL;
                    endcase
                end else begin
                    case (funct3)
                        3'b000:  op = (opb5 && funct7b5) ? OP_SUB : OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = funct7b5 ? OP_SRA : OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end
            end
            default: op = OP_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle integer ops plus an iterative
// shift-add multiplier and restoring divider, behind a valid/ready pair.
//
// state | meaning
// IDLE  | ready to accept a new operation
// BUSY  | mul/div iterating one bit per cycle
// DONE  | result held until the consumer takes it
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            opb5,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

    alu_op_t         dec_op;
    alu_op_t         op_q;
    alu_state_t      state_q, state_d;
    logic [XLEN-1:0] acc_hi_q, acc_lo_q, opnd_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_nxt;
    logic [XLEN-1:0] result_q;
    logic            zero_q, illegal_q;

    logic            accept, is_div_dec, go_busy, iter_last, is_mul_q;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_sub, nxt_hi, nxt_lo, iter_res;
    logic            div_ge;

    alu_op_decoder u_dec (
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .opb5     (opb5),
        .op       (dec_op)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal    = illegal_q;

    assign accept     = in_valid && in_ready && !flush;
    assign is_div_dec = (dec_op == OP_DIVU) || (dec_op == OP_REMU);
    // Divide by zero has a fixed answer, so it skips the iterative engine.
    assign go_busy    = (dec_op == OP_MUL) || (dec_op == OP_MULHU) ||
                        (is_div_dec && (b != '0));
    assign is_mul_q   = (op_q == OP_MUL) || (op_q == OP_MULHU);
    assign cnt_nxt    = cnt_q + CW'(1);
    assign iter_last  = (cnt_nxt == CNT_LAST);
    assign shamt      = b[SHW-1:0];

    // Single-cycle result; also supplies the divide-by-zero and ILLEGAL answers.
    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_DIVU: alu_res = '1;
            OP_REMU: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // One mul/div step. Mul: {hi,lo} shifts right with conditional add of a.
    // Div: hi is the partial remainder, lo shifts the dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {XLEN{1'b0}})};
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_sub   = div_shift[XLEN-1:0] - opnd_q;
        if (is_mul_q) begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end else begin
            nxt_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
            nxt_lo = {acc_lo_q[XLEN-2:0], div_ge};
        end
        iter_res = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? nxt_lo : nxt_hi;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept)    state_d = go_busy ? ST_BUSY : ST_DONE;
                ST_BUSY: if (iter_last) state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default:                state_d = ST_IDLE;
            endcase
        end
    end

    // Operand capture, iteration registers and the held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_ADD;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                op_q  <= dec_op;
                cnt_q <= '0;
                if (go_busy) begin
                    acc_hi_q <= '0;
                    acc_lo_q <= is_div_dec ? a : b;
                    opnd_q   <= is_div_dec ? b : a;
                end else begin
                    result_q  <= alu_res;
                    zero_q    <= (alu_res == '0);
                    illegal_q <= (dec_op == OP_ILLEGAL);
                end
            end
        end else if (state_q == ST_BUSY) begin
            acc_hi_q <= nxt_hi;
            acc_lo_q <= nxt_lo;
            cnt_q    <= cnt_nxt;
            if (iter_last) begin
                result_q  <= iter_res;
                zero_q    <= (iter_res == '0);
                illegal_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit at XLEN=32 with hand-computed expectations.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic        funct7b5, funct7b0, opb5;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int passed = 0;
    int total  = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ALUOp     (ALUOp),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .funct7b0  (funct7b0),
        .opb5      (opb5),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one operation at a negedge; returns after the accept edge (+1).
    task automatic offer(input logic [1:0] aop, input logic [2:0] f3, input logic f7b5,
                         input logic f7b0, input logic ob5,
                         input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        ALUOp = aop; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opb5 = ob5;
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic f7b5, input logic f7b0, input logic ob5,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        offer(aop, f3, f7b5, f7b0, ob5, av, bv);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_zero"}, 64'(zero), 64'(exp_res == 32'd0));
        check({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
        @(negedge clk);
        out_ready = 1'b1;
        check({tag, "_rdy_hs"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_vld_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] held;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        a = '0; b = '0; ALUOp = '0; funct3 = '0; funct7b5 = 1'b0; funct7b0 = 1'b0; opb5 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_res", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_ill", 64'(illegal), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        run_op("sub_r",  2'b10, 3'b000, 1, 0, 1, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1);
        run_op("add_i",  2'b10, 3'b000, 1, 0, 0, 32'd5, 32'd7, 32'd12, 0, 1);
        run_op("add_00", 2'b00, 3'b111, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
        run_op("sub_01", 2'b01, 3'b000, 0, 0, 0, 32'd3, 32'd3, 32'd0, 0, 1);
        run_op("sra",    2'b10, 3'b101, 1, 0, 1, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1);
        run_op("srl",    2'b10, 3'b101, 0, 0, 1, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 1);
        run_op("sll_m",  2'b10, 3'b001, 0, 0, 1, 32'd1, 32'h21, 32'd2, 0, 1);
        run_op("slt",    2'b10, 3'b010, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1);
        run_op("sltu",   2'b10, 3'b011, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
        run_op("xor",    2'b10, 3'b100, 0, 0, 1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 0, 1);
        run_op("or",     2'b10, 3'b110, 0, 0, 1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 0, 1);
        run_op("and",    2'b10, 3'b111, 0, 0, 1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 0, 1);

        run_op("mulhu",  2'b10, 3'b011, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33);
        run_op("mul",    2'b10, 3'b000, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 33);
        run_op("mul2",   2'b10, 3'b000, 0, 1, 1, 32'h1234_5678, 32'h10, 32'h2345_6780, 0, 33);
        run_op("mulhu2", 2'b10, 3'b011, 0, 1, 1, 32'h1234_5678, 32'h10, 32'h0000_0001, 0, 33);
        run_op("divu0",  2'b10, 3'b101, 0, 1, 1, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, 1);
        run_op("remu0",  2'b10, 3'b111, 0, 1, 1, 32'd100, 32'd0, 32'd100, 0, 1);
        run_op("remu",   2'b10, 3'b111, 0, 1, 1, 32'd100, 32'd7, 32'd2, 0, 33);
        run_op("divu",   2'b10, 3'b101, 0, 1, 1, 32'd100, 32'd7, 32'd14, 0, 33);

        run_op("ill_11", 2'b11, 3'b000, 0, 0, 1, 32'd9, 32'd9, 32'd0, 1, 1);
        run_op("ill_m1", 2'b10, 3'b001, 0, 1, 1, 32'd9, 32'd9, 32'd0, 1, 1);

        // Result held across a stalled consumer.
        offer(2'b10, 3'b000, 0, 0, 1, 32'd40, 32'd2);
        check("hold_vld0", 64'(out_valid), 64'd1);
        held = result;
        check("hold_val", 64'(held), 64'd42);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result !== 32'd42 || in_ready !== 1'b0 || out_valid !== 1'b1) seen++;
        end
        check("hold_stable", 64'(seen), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_release", 64'(in_ready), 64'd1);

        // Flush in the fifth BUSY cycle of a multiply.
        offer(2'b10, 3'b000, 0, 1, 1, 32'd3, 32'd5);
        check("fl_busy", 64'(in_ready), 64'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_idle", 64'(in_ready), 64'd1);
        check("fl_vld", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("fl_no_vld", 64'(seen), 64'd0);

        // Flush wins over a same-cycle offer.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; ALUOp = 2'b00; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flacc_rdy", 64'(in_ready), 64'd1);
        check("flacc_vld", 64'(out_valid), 64'd0);

        // Reset while a divide iterates.
        offer(2'b10, 3'b101, 0, 1, 1, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rb_rdy", 64'(in_ready), 64'd1);
        check("rb_res", 64'(result), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rb_no_vld", 64'(seen), 64'd0);

        run_op("post_rst", 2'b10, 3'b000, 0, 0, 0, 32'd8, 32'd9, 32'd17, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept.
- a, b  in  XLEN  operands.
- ALUOp  in  2  class from main decoder.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  funct7[5].
- funct7b0  in  1  funct7[0], M-extension select.
- opb5  in  1  opcode[5], R-type vs I-type.
- flush  in  1  abort in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0.
- illegal  out  1  undecodable operation.
REQ-003 Clocking/reset SHALL be exactly: one clock; reset is synchronous and active-high.

Function
REQ-004 Accept SHALL occur on a rising edge with in_valid & in_ready; all inputs sampled only then.
REQ-005 Decode to 4-bit alu_op_t: ALUOp 00 -> ADD; 01 -> SUB; 11 -> ILLEGAL; 10 -> funct3 table below.
REQ-006 ALUOp=10, not M: 000 ADD, or SUB when opb5&funct7b5; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA when funct7b5, else SRL; 110 OR; 111 AND.
REQ-007 ALUOp=10 with opb5&funct7b0 selects M: 000 MUL; 011 MULHU; 101 DIVU; 111 REMU; other funct3 -> ILLEGAL.
REQ-008 Arithmetic modulo 2^XLEN; SLT signed, SLTU unsigned, result 0 or 1; shift amount b[$clog2(XLEN)-1:0].
REQ-009 ILLEGAL SHALL produce result 0 and illegal=1 with single-cycle latency.
REQ-010 FSM states IDLE, BUSY, DONE. IDLE: in_ready=1. BUSY and DONE: in_ready=0.
REQ-011 Single-cycle ops and ILLEGAL: IDLE -> DONE; out_valid asserted the cycle after accept.
REQ-012 MUL/MULHU: IDLE -> BUSY; iterative shift-add, one bit per cycle over XLEN cycles, then DONE; out_valid XLEN+1 cycles after accept. MUL returns low XLEN bits, MULHU high XLEN bits of the unsigned product.
REQ-013 DIVU/REMU: restoring division, one bit per cycle, same XLEN+1 latency as MUL.
REQ-014 Divide by zero SHALL bypass BUSY and go to DONE with 1-cycle latency: DIVU returns all ones, REMU returns a.
REQ-015 DONE SHALL hold result, zero, illegal and out_valid stable until out_ready; on out_valid&out_ready go to IDLE.
REQ-016 in_ready SHALL not rise in the handshake cycle, so there is no back-to-back accept; throughput is at most 1 op per 2 cycles.
REQ-017 flush SHALL return the unit to IDLE next cycle from any state, deassert out_valid, and discard the result; flush beats a same-cycle accept.
REQ-018 Iteration counter width SHALL be $clog2(XLEN)+1 and SHALL reach exactly XLEN with no off-by-one.

Reset
REQ-019 On reset: state IDLE, out_valid=0, result=0, zero=0, illegal=0, counter=0, datapath registers 0.
REQ-020 Reset asserted during BUSY or DONE SHALL abandon the operation; no out_valid is produced for it.

Structure
REQ-021 Package alu_pkg SHALL hold alu_op_t, the FSM state enum, and the ALUOp encodings.
REQ-022 Decode SHALL be a combinational sub-module alu_op_decoder. It covers REQ-005 to REQ-007.
REQ-023 Single-cycle datapath, iterative mul/div engine and FSM SHALL live in alu_exec_unit.

Verification (XLEN=32)
REQ-024 ALUOp=10, funct3=000, opb5=1, funct7b5=1, a=5, b=7 -> next cycle out_valid, result=0xFFFFFFFE, zero=0.
REQ-025 SRA a=0x80000000, b=4, funct7b5=1 -> result 0xF8000000; SRL with the same operands -> 0x08000000.
REQ-026 MULHU a=b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-027 DIVU a=100, b=0 -> 1 cycle, result 0xFFFFFFFF; REMU a=100, b=7 -> 33 cycles, result 2.
REQ-028 out_ready held low 10 cycles in DONE -> result stable, in_ready=0 throughout; flush at BUSY cycle 5 -> IDLE next cycle, no out_valid.
REQ-029 ALUOp=11, or M funct3=001 -> illegal=1, result 0, zero=1, out_valid next cycle.
